fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-index width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 id_valid  input  1  ID stage holds a valid instruction.
REQ-006 id_rs1, id_rs2  input  REG_AW each  ID source register indices.
REQ-007 id_rs1_used, id_rs2_used  input  1 each  ID instruction reads that source.
REQ-008 id_rd  input  REG_AW  ID destination index.
REQ-009 id_reg_write, id_mem_read  input  1 each  ID instruction writes rd / is a load.
REQ-010 ex_flush  input  1  taken branch/jump resolved in EX; kill IF/ID and ID/EX.
REQ-011 fwd_a_sel, fwd_b_sel  output  2 each  EX operand mux selects: 00 regfile, 01 MEM/WB result, 10 EX/MEM result; 11 never driven.
REQ-012 stall  output  1  hold PC and IF/ID this cycle.
REQ-013 bubble  output  1  load NOP into ID/EX this cycle.
REQ-014 flush_ifid  output  1  invalidate IF/ID this cycle.
REQ-015 stall_cnt  output  CNT_W  saturating count of load-use stall cycles.

Function
REQ-016 Block SHALL keep shadow stage registers: ID/EX {valid, rs1, rs2, rs1_used, rs2_used, rd, reg_write, mem_read}, EX/MEM {valid, rd, reg_write}, MEM/WB {valid, rd, reg_write}.
REQ-017 Each cycle, EX/MEM SHALL load from ID/EX and MEM/WB SHALL load from EX/MEM, unconditionally.
REQ-018 ID/EX SHALL load ID inputs when stall=0, bubble=0, ex_flush=0; otherwise load valid=0 with reg_write=0, mem_read=0.
REQ-019 fwd_a_sel SHALL be combinational from shadow registers: 10 if EX/MEM valid, reg_write, rd!=0, rd==ID/EX.rs1, rs1_used; else 01 under same test on MEM/WB; else 00.
REQ-020 fwd_b_sel SHALL follow REQ-019 using rs2/rs2_used.
REQ-021 EX/MEM match SHALL win over MEM/WB match (youngest producer).
REQ-022 Register 0 SHALL never be forwarded; sel=00 when rs==0.
REQ-023 fwd_*_sel SHALL be 00 when ID/EX.valid=0.
REQ-024 Load-use hazard = id_valid & ID/EX.valid & ID/EX.mem_read & ID/EX.rd!=0 & ((id_rs1_used & id_rs1==ID/EX.rd) | (id_rs2_used & id_rs2==ID/EX.rd)).
REQ-025 On load-use hazard with ex_flush=0: stall=1, bubble=1, for exactly one cycle (bubble clears the load from ID/EX, so hazard self-clears next cycle).
REQ-026 ex_flush=1 SHALL force flush_ifid=1, bubble=1, stall=0, overriding any load-use hazard the same cycle.
REQ-027 stall, bubble, flush_ifid SHALL be combinational, same-cycle (zero latency).
REQ-028 stall_cnt SHALL increment by 1 on each cycle with stall=1; SHALL saturate at all-ones, no wrap.
REQ-029 Back-to-back dependent loads SHALL each produce one stall cycle; no stall when dependent instruction is two or more slots behind the load (covered by 01/10 forwarding).

Reset
REQ-030 rst=1 at a clock edge SHALL clear all shadow valid, reg_write, mem_read bits and stall_cnt to 0; index fields to 0.
REQ-031 After reset: fwd_a_sel=fwd_b_sel=00, stall=0, bubble=0, flush_ifid=ex_flush (combinational pass).
REQ-032 Reset mid-stall SHALL discard the pending hazard; no stall the cycle after reset release unless new inputs create one.

Structure
REQ-033 Forward select encodings (FWD_RF=00, FWD_WB=01, FWD_MEM=10) SHALL live in the shared CPU package/header used by the operand muxes.
REQ-034 One sub-module, fwd_sel_logic, SHALL compute a single 2-bit select from (rs, rs_used, EX/MEM, MEM/WB fields); instantiated twice (A, B).

Verification
REQ-035 Reset: rst high 2 cycles -> all outputs 00/0, stall_cnt=0.
REQ-036 ALU chain: add x5 then add x6,x5,x1 next slot -> fwd_a_sel=10 in EX of second; one slot gap -> fwd_a_sel=01; x5 written by both older slots -> 10.
REQ-037 Load-use: lw x7 then add x8,x7,x7 -> stall=1, bubble=1 one cycle, then fwd_a_sel=fwd_b_sel=01; stall_cnt=1.
REQ-038 x0: lw x0 followed by use of x0 -> no stall, sels 00.
REQ-039 Flush vs stall: load-use hazard with ex_flush=1 same cycle -> stall=0, bubble=1, flush_ifid=1, stall_cnt unchanged.
REQ-040 Saturation: CNT_W=4, 20 load-use pairs -> stall_cnt holds 15.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared CPU pipeline definitions: EX operand forwarding mux select encodings.
package fwd_hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/fwd_sel_logic.sv
// Forwarding select for one EX operand; the youngest matching producer wins.
module fwd_sel_logic
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              idex_valid,
    input  logic [REG_AW-1:0] rs,
    input  logic              rs_used,
    input  logic              exmem_valid,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              memwb_valid,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    output fwd_sel_e          sel
);

    always_comb begin
        sel = FWD_RF;
        // x0 is hard-wired zero, so it is never a forwarding target.
        if (idex_valid && rs_used && (rs != '0)) begin
            if (exmem_valid && exmem_reg_write && (exmem_rd == rs)) begin
                sel = FWD_MEM;
            end else if (memwb_valid && memwb_reg_write && (memwb_rd == rs)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit with shadow ID/EX, EX/MEM and MEM/WB state.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic              bubble,
    output logic              flush_ifid,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              idex_valid, idex_rs1_used, idex_rs2_used, idex_reg_write, idex_mem_read;
    logic [REG_AW-1:0] idex_rs1, idex_rs2, idex_rd;
    logic              exmem_valid, exmem_reg_write;
    logic [REG_AW-1:0] exmem_rd;
    logic              memwb_valid, memwb_reg_write;
    logic [REG_AW-1:0] memwb_rd;
    logic [CNT_W-1:0]  cnt_q;
    logic              load_use;
    fwd_sel_e          sel_a, sel_b;

    always_comb begin
        load_use = id_valid && idex_valid && idex_mem_read && (idex_rd != '0) &&
                   ((id_rs1_used && (id_rs1 == idex_rd)) ||
                    (id_rs2_used && (id_rs2 == idex_rd)));
        // A flush kills the dependent instruction anyway, so it overrides the stall.
        stall      = load_use && !ex_flush;
        bubble     = load_use || ex_flush;
        flush_ifid = ex_flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_valid      <= 1'b0;
            idex_rs1        <= '0;
            idex_rs2        <= '0;
            idex_rs1_used   <= 1'b0;
            idex_rs2_used   <= 1'b0;
            idex_rd         <= '0;
            idex_reg_write  <= 1'b0;
            idex_mem_read   <= 1'b0;
            exmem_valid     <= 1'b0;
            exmem_rd        <= '0;
            exmem_reg_write <= 1'b0;
            memwb_valid     <= 1'b0;
            memwb_rd        <= '0;
            memwb_reg_write <= 1'b0;
            cnt_q           <= '0;
        end else begin
            if (bubble) begin
                idex_valid     <= 1'b0;
                idex_rs1       <= '0;
                idex_rs2       <= '0;
                idex_rs1_used  <= 1'b0;
                idex_rs2_used  <= 1'b0;
                idex_rd        <= '0;
                idex_reg_write <= 1'b0;
                idex_mem_read  <= 1'b0;
            end else begin
                idex_valid     <= id_valid;
                idex_rs1       <= id_rs1;
                idex_rs2       <= id_rs2;
                idex_rs1_used  <= id_rs1_used;
                idex_rs2_used  <= id_rs2_used;
                idex_rd        <= id_rd;
                idex_reg_write <= id_reg_write;
                idex_mem_read  <= id_mem_read;
            end
            exmem_valid     <= idex_valid;
            exmem_rd        <= idex_rd;
            exmem_reg_write <= idex_reg_write;
            memwb_valid     <= exmem_valid;
            memwb_rd        <= exmem_rd;
            memwb_reg_write <= exmem_reg_write;
            if (stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    fwd_sel_logic #(.REG_AW(REG_AW)) u_fwd_a (
        .idex_valid      (idex_valid),
        .rs              (idex_rs1),
        .rs_used         (idex_rs1_used),
        .exmem_valid     (exmem_valid),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_valid     (memwb_valid),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .sel             (sel_a)
    );

    fwd_sel_logic #(.REG_AW(REG_AW)) u_fwd_b (
        .idex_valid      (idex_valid),
        .rs              (idex_rs2),
        .rs_used         (idex_rs2_used),
        .exmem_valid     (exmem_valid),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_valid     (memwb_valid),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .sel             (sel_b)
    );

    assign fwd_a_sel = sel_a;
    assign fwd_b_sel = sel_b;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: instruction-stream model predicts forwarding, stalls and the stall counter.
module tb_fwd_hazard_unit;

    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          id_reg_write = 1'b0, id_mem_read = 1'b0, ex_flush = 1'b0;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          stall, bubble, flush_ifid;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .ex_flush     (ex_flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall),
        .bubble       (bubble),
        .flush_ifid   (flush_ifid),
        .stall_cnt    (stall_cnt)
    );

    typedef struct {
        bit          v;
        bit [AW-1:0] rs1, rs2;
        bit          u1, u2;
        bit [AW-1:0] rd;
        bit          rw, mr;
    } ins_t;

    typedef struct {
        bit [1:0] fa, fb;
        bit       st, bu, fl;
        int       cnt;
    } exp_t;

    exp_t sb[$];
    // hist[0] is the instruction in EX, hist[1] one slot older, hist[2] two slots older.
    ins_t hist[3];
    int   mcnt   = 0;
    int   checks = 0;
    int   errors = 0;
    ins_t nop;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit rw, bit mr);
        ins_t i;
        i.v = v; i.rs1 = AW'(rs1); i.u1 = u1; i.rs2 = AW'(rs2); i.u2 = u2;
        i.rd = AW'(rd); i.rw = rw; i.mr = mr;
        return i;
    endfunction

    // Youngest older instruction still in flight that writes the source supplies it.
    function automatic bit [1:0] ref_sel(bit [AW-1:0] rs, bit used);
        if (!hist[0].v || !used || rs == 0) return 2'b00;
        for (int d = 1; d <= 2; d++) begin
            if (hist[d].v && hist[d].rw && hist[d].rd == rs) return (d == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic cycle(input ins_t i, input bit fl, input bit r, output exp_t e);
        bit lu;
        @(negedge clk);
        rst = r;
        id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rs1_used = i.u1;
        id_rs2_used = i.u2; id_rd = i.rd; id_reg_write = i.rw; id_mem_read = i.mr;
        ex_flush = fl;
        #1;
        lu = i.v && hist[0].v && hist[0].mr && hist[0].rd != 0 &&
             ((i.u1 && i.rs1 == hist[0].rd) || (i.u2 && i.rs2 == hist[0].rd));
        e.fa  = ref_sel(hist[0].rs1, hist[0].u1);
        e.fb  = ref_sel(hist[0].rs2, hist[0].u2);
        e.st  = lu && !fl;
        e.bu  = lu || fl;
        e.fl  = fl;
        e.cnt = mcnt;
        sb.push_back(e);
        if (r) begin
            foreach (hist[k]) hist[k] = nop;
            mcnt = 0;
        end else begin
            if (e.st && mcnt < (1 << CW) - 1) mcnt++;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = e.bu ? nop : i;
        end
    endtask

    // Present an instruction, re-presenting it while the unit holds IF/ID.
    task automatic issue(input ins_t i, input bit fl);
        exp_t e;
        cycle(i, fl, 1'b0, e);
        for (int k = 0; k < 3 && e.st; k++) cycle(i, fl, 1'b0, e);
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) cycle(nop, 1'b0, 1'b1, e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_fwd_a", 32'(fwd_a_sel), 32'(e.fa));
                chk("sb_fwd_b", 32'(fwd_b_sel), 32'(e.fb));
                chk("sb_stall", 32'(stall), 32'(e.st));
                chk("sb_bubble", 32'(bubble), 32'(e.bu));
                chk("sb_flush_ifid", 32'(flush_ifid), 32'(e.fl));
                chk("sb_stall_cnt", 32'(stall_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        exp_t e;
        ins_t add5, use5, lw7, use7, lw0, use0, r;
        int   cnt_before;
        nop = '{default: 0};
        foreach (hist[k]) hist[k] = nop;
        add5 = mk(1, 1, 1, 2, 1, 5, 1, 0);
        use5 = mk(1, 5, 1, 1, 1, 6, 1, 0);
        lw7  = mk(1, 2, 1, 0, 0, 7, 1, 1);
        use7 = mk(1, 7, 1, 7, 1, 8, 1, 0);
        lw0  = mk(1, 2, 1, 0, 0, 0, 1, 1);
        use0 = mk(1, 0, 1, 0, 1, 9, 1, 0);

        // Reset: model is cleared only on the rst edge, so X-free initial state is assumed zero.
        do_reset(2);
        cycle(nop, 1'b1, 1'b0, e);
        chk("rst_fwd_a", 32'(fwd_a_sel), 0);
        chk("rst_fwd_b", 32'(fwd_b_sel), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_cnt", 32'(stall_cnt), 0);
        chk("rst_flush_pass", 32'(flush_ifid), 1);

        // ALU chain: adjacent, one-slot gap, and two older writers of x5.
        issue(add5, 0); issue(use5, 0); issue(nop, 0);
        chk("alu_adj_fwd_a", 32'(fwd_a_sel), 2);
        chk("alu_adj_fwd_b", 32'(fwd_b_sel), 0);
        issue(add5, 0); issue(nop, 0); issue(use5, 0); issue(nop, 0);
        chk("alu_gap_fwd_a", 32'(fwd_a_sel), 1);
        issue(add5, 0); issue(add5, 0); issue(use5, 0); issue(nop, 0);
        chk("alu_both_fwd_a", 32'(fwd_a_sel), 2);

        // Load-use from a clean counter.
        do_reset(1);
        cycle(lw7, 0, 0, e);
        cycle(use7, 0, 0, e);
        chk("lu_stall", 32'(stall), 1);
        chk("lu_bubble", 32'(bubble), 1);
        cycle(use7, 0, 0, e);
        chk("lu_stall_clears", 32'(stall), 0);
        cycle(nop, 0, 0, e);
        chk("lu_fwd_a", 32'(fwd_a_sel), 1);
        chk("lu_fwd_b", 32'(fwd_b_sel), 1);
        chk("lu_cnt", 32'(stall_cnt), 1);

        // Load into x0 never stalls or forwards.
        cycle(lw0, 0, 0, e);
        cycle(use0, 0, 0, e);
        chk("x0_stall", 32'(stall), 0);
        cycle(nop, 0, 0, e);
        chk("x0_fwd_a", 32'(fwd_a_sel), 0);
        chk("x0_fwd_b", 32'(fwd_b_sel), 0);

        // Flush overrides a same-cycle load-use hazard.
        cycle(lw7, 0, 0, e);
        cnt_before = int'(stall_cnt);
        cycle(use7, 1, 0, e);
        chk("fl_stall", 32'(stall), 0);
        chk("fl_bubble", 32'(bubble), 1);
        chk("fl_flush_ifid", 32'(flush_ifid), 1);
        cycle(nop, 0, 0, e);
        chk("fl_cnt_held", 32'(stall_cnt), 32'(cnt_before));

        // Reset in the middle of a load-use stall discards the hazard.
        cycle(lw7, 0, 0, e);
        cycle(use7, 0, 1, e);
        cycle(use7, 0, 0, e);
        chk("rst_mid_stall", 32'(stall), 0);

        // Saturation of the 4-bit counter.
        do_reset(1);
        for (int k = 0; k < 20; k++) begin
            issue(lw7, 0);
            issue(use7, 0);
        end
        chk("sat_cnt", 32'(stall_cnt), 15);

        // Randomized stream with occasional flushes and resets.
        do_reset(1);
        for (int k = 0; k < 600; k++) begin
            r.v  = ($urandom_range(0, 9) != 0);
            r.rs1 = AW'($urandom_range(0, 7));
            r.rs2 = AW'($urandom_range(0, 7));
            r.u1 = ($urandom_range(0, 3) != 0);
            r.u2 = ($urandom_range(0, 1) != 0);
            r.rd = AW'($urandom_range(0, 7));
            r.rw = ($urandom_range(0, 3) != 0);
            r.mr = r.rw && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0) do_reset(1);
            else issue(r, ($urandom_range(0, 11) == 0));
        end

        repeat (3) @(negedge clk);
        #3;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
